// File: rtl/pic_init_control.sv
// 8259A command-word sequencer: ICW1..ICW4 init FSM, IMR/OCW3 state and read-data mux.
// Strobes are edge-detected so a held write acts exactly once.
module pic_init_control #(
  parameter logic [7:0] IMR_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] internal_data_bus,
  input  logic       write_initial_command_word_1,
  input  logic       write_operation_control_word_1,
  input  logic       write_operation_control_word_3,
  input  logic       read,
  input  logic       A0,
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  output logic       init_done,
  output logic       ltim,
  output logic       sngl,
  output logic       ic4,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_config,
  output logic       upm,
  output logic       aeoi,
  output logic [1:0] buf_ms,
  output logic       sfnm,
  output logic [7:0] interrupt_mask,
  output logic       read_isr_select,
  output logic       special_mask_mode,
  output logic       poll_command,
  output logic [7:0] data_bus_out,
  output logic       data_bus_out_en
);

  typedef enum logic [2:0] {S_ICW1, S_ICW2, S_ICW3, S_ICW4, S_READY} state_t;

  state_t     r_state, w_next;
  logic       r_icw1_q, r_a0_q, r_ocw3_q;
  logic       w_icw1_ev, w_a0_ev, w_ocw3_ev;
  logic       w_do_ocw3, w_do_a0;
  logic       w_ld_icw2, w_ld_icw3, w_ld_icw4, w_ld_ocw1;
  logic [7:0] w_d;

  assign w_d       = internal_data_bus;
  assign w_icw1_ev = write_initial_command_word_1   & ~r_icw1_q;
  assign w_a0_ev   = write_operation_control_word_1 & ~r_a0_q;
  assign w_ocw3_ev = write_operation_control_word_3 & ~r_ocw3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_icw1_q <= 1'b0;
      r_a0_q   <= 1'b0;
      r_ocw3_q <= 1'b0;
    end else begin
      r_icw1_q <= write_initial_command_word_1;
      r_a0_q   <= write_operation_control_word_1;
      r_ocw3_q <= write_operation_control_word_3;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_ICW1;
    else       r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    if (w_icw1_ev) begin
      w_next = S_ICW2;
    end else if (w_do_a0) begin
      case (r_state)
        S_ICW2:  w_next = !sngl ? S_ICW3 : (ic4 ? S_ICW4 : S_READY);
        S_ICW3:  w_next = ic4 ? S_ICW4 : S_READY;
        S_ICW4:  w_next = S_READY;
        default: w_next = r_state;
      endcase
    end
  end

  // FSM: action decode; an acting OCW3 shadows a coincident A0 write
  always_comb begin
    w_do_ocw3 = ~w_icw1_ev & w_ocw3_ev & (r_state == S_READY);
    w_do_a0   = ~w_icw1_ev & ~w_do_ocw3 & w_a0_ev;
    w_ld_icw2 = w_do_a0 & (r_state == S_ICW2);
    w_ld_icw3 = w_do_a0 & (r_state == S_ICW3);
    w_ld_icw4 = w_do_a0 & (r_state == S_ICW4);
    w_ld_ocw1 = w_do_a0 & (r_state == S_READY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      init_done         <= 1'b0;
      ltim              <= 1'b0;
      sngl              <= 1'b0;
      ic4               <= 1'b0;
      vector_base       <= '0;
      cascade_config    <= '0;
      upm               <= 1'b0;
      aeoi              <= 1'b0;
      buf_ms            <= '0;
      sfnm              <= 1'b0;
      interrupt_mask    <= IMR_INIT;
      read_isr_select   <= 1'b0;
      special_mask_mode <= 1'b0;
      poll_command      <= 1'b0;
    end else begin
      // tracks the state register so init_done rises with READY
      init_done    <= (w_next == S_READY);
      poll_command <= w_do_ocw3 & w_d[2];
      if (w_icw1_ev) begin
        ltim              <= w_d[3];
        sngl              <= w_d[1];
        ic4               <= w_d[0];
        interrupt_mask    <= IMR_INIT;
        upm               <= 1'b0;
        aeoi              <= 1'b0;
        buf_ms            <= '0;
        sfnm              <= 1'b0;
        read_isr_select   <= 1'b0;
        special_mask_mode <= 1'b0;
      end else begin
        if (w_ld_icw2) vector_base    <= w_d[7:3];
        if (w_ld_icw3) cascade_config <= w_d;
        if (w_ld_icw4) begin
          upm    <= w_d[0];
          aeoi   <= w_d[1];
          buf_ms <= w_d[3:2];
          sfnm   <= w_d[4];
        end
        if (w_ld_ocw1) interrupt_mask <= w_d;
        if (w_do_ocw3 && w_d[1]) read_isr_select   <= w_d[0];
        if (w_do_ocw3 && w_d[6]) special_mask_mode <= w_d[5];
      end
    end
  end

  always_comb begin
    data_bus_out = 8'h00;
    if (read) data_bus_out = A0 ? interrupt_mask : (read_isr_select ? isr : irr);
  end
  assign data_bus_out_en = read;

endmodule

// File: tb/tb_pic_init_control.sv
// Bench for pic_init_control: directed init/OCW scenarios, then random strobes
// compared every cycle against a queue-based model of the pending ICW words.
module tb_pic_init_control;
  localparam logic [7:0] IMR_P = 8'h3C;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bus;
  logic       s1, sa, s3, rd, a0;
  logic [7:0] irr, isr;
  logic       init_done, ltim, sngl, ic4, upm, aeoi, sfnm;
  logic [4:0] vector_base;
  logic [7:0] cascade_config, interrupt_mask, data_bus_out;
  logic [1:0] buf_ms;
  logic       read_isr_select, special_mask_mode, poll_command, data_bus_out_en;

  pic_init_control #(.IMR_INIT(IMR_P)) dut (
    .clk(clk), .reset(reset), .internal_data_bus(bus),
    .write_initial_command_word_1(s1), .write_operation_control_word_1(sa),
    .write_operation_control_word_3(s3), .read(rd), .A0(a0), .irr(irr), .isr(isr),
    .init_done(init_done), .ltim(ltim), .sngl(sngl), .ic4(ic4),
    .vector_base(vector_base), .cascade_config(cascade_config), .upm(upm),
    .aeoi(aeoi), .buf_ms(buf_ms), .sfnm(sfnm), .interrupt_mask(interrupt_mask),
    .read_isr_select(read_isr_select), .special_mask_mode(special_mask_mode),
    .poll_command(poll_command), .data_bus_out(data_bus_out),
    .data_bus_out_en(data_bus_out_en)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference model: pending ICW words kept as a queue of word numbers
  int         m_q[$];
  logic       m_seen, m_p1, m_pa, m_p3;
  logic       m_ltim, m_sngl, m_ic4, m_upm, m_aeoi, m_sfnm, m_ris, m_smm, m_poll;
  logic [4:0] m_vb;
  logic [7:0] m_cas, m_imr;
  logic [1:0] m_bms;

  function automatic logic m_ready();
    return m_seen && (m_q.size() == 0);
  endfunction

  task automatic model_edge();
    logic e1, ea, e3, pn;
    int   k;
    if (reset) begin
      m_q.delete(); m_seen = 0; m_p1 = 0; m_pa = 0; m_p3 = 0;
      {m_ltim, m_sngl, m_ic4, m_upm, m_aeoi, m_sfnm, m_ris, m_smm, m_poll} = '0;
      m_vb = 0; m_cas = 0; m_bms = 0; m_imr = IMR_P;
      return;
    end
    e1 = s1 & ~m_p1; ea = sa & ~m_pa; e3 = s3 & ~m_p3; pn = 0;
    if (e1) begin
      m_ltim = bus[3]; m_sngl = bus[1]; m_ic4 = bus[0];
      m_imr = IMR_P; {m_upm, m_aeoi, m_bms, m_sfnm, m_ris, m_smm} = '0;
      m_q.delete(); m_q.push_back(2);
      if (!bus[1]) m_q.push_back(3);
      if (bus[0])  m_q.push_back(4);
      m_seen = 1;
    end else if (e3 && m_ready()) begin
      if (bus[1]) m_ris = bus[0];
      if (bus[6]) m_smm = bus[5];
      pn = bus[2];
    end else if (ea) begin
      if (m_ready()) m_imr = bus;
      else if (m_q.size() > 0) begin
        k = m_q.pop_front();
        case (k)
          2: m_vb = bus[7:3];
          3: m_cas = bus;
          default: begin
            m_upm = bus[0]; m_aeoi = bus[1]; m_bms = bus[3:2]; m_sfnm = bus[4];
          end
        endcase
      end
    end
    m_poll = pn; m_p1 = s1; m_pa = sa; m_p3 = s3;
  endtask

  task automatic check_all();
    logic [7:0] rx;
    rx = !rd ? 8'h00 : (a0 ? m_imr : (m_ris ? isr : irr));
    chk("init_done", init_done, m_ready());
    chk("icw1", {ltim, sngl, ic4}, {m_ltim, m_sngl, m_ic4});
    chk("vector_base", vector_base, m_vb);
    chk("cascade", cascade_config, m_cas);
    chk("icw4", {upm, aeoi, buf_ms, sfnm}, {m_upm, m_aeoi, m_bms, m_sfnm});
    chk("imr", interrupt_mask, m_imr);
    chk("ocw3", {read_isr_select, special_mask_mode}, {m_ris, m_smm});
    chk("poll", poll_command, m_poll);
    chk("dbo", data_bus_out, rx);
    chk("dbo_en", data_bus_out_en, rd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wr1(input logic [7:0] d);
    bus = d; s1 = 1; tick(); s1 = 0; tick();
  endtask
  task automatic wra(input logic [7:0] d);
    bus = d; sa = 1; tick(); sa = 0; tick();
  endtask
  task automatic wr3(input logic [7:0] d);
    bus = d; s3 = 1; tick(); s3 = 0; tick();
  endtask

  initial begin
    reset = 1; bus = 0; s1 = 0; sa = 0; s3 = 0; rd = 0; a0 = 0; irr = 8'h11; isr = 8'h22;
    tick(); tick();
    chk("rst_imr", interrupt_mask, IMR_P);
    chk("rst_done", init_done, 0);
    reset = 0; tick();

    // single, with ICW4
    wr1(8'h13); wra(8'h48);
    chk("t1_wait_icw4", init_done, 0);
    wra(8'h03);
    chk("t1_vb", vector_base, 5'h09);
    chk("t1_upm_aeoi", {upm, aeoi}, 2'b11);
    chk("t1_done", init_done, 1);

    // cascade, no ICW4
    wr1(8'h10); wra(8'h20);
    chk("t2_wait_icw3", init_done, 0);
    wra(8'h04);
    chk("t2_cas", cascade_config, 8'h04);
    chk("t2_done", init_done, 1);
    chk("t2_upm_aeoi", {upm, aeoi}, 2'b00);

    // held OCW1 acts once
    bus = 8'hA5; sa = 1; tick(); bus = 8'hFF;
    for (int i = 0; i < 9; i++) tick();
    sa = 0; tick();
    chk("t3_imr", interrupt_mask, 8'hA5);
    rd = 1; a0 = 1; tick();
    chk("t3_read", data_bus_out, 8'hA5);

    // OCW3 controls
    rd = 0; wr3(8'h0B);
    rd = 1; a0 = 0; tick();
    chk("t4_isr_read", data_bus_out, 8'h22);
    rd = 0; wr3(8'h68);
    chk("t4_smm", special_mask_mode, 1);
    bus = 8'h0C; s3 = 1; tick();
    chk("t4_poll_hi", poll_command, 1);
    tick();
    chk("t4_poll_lo", poll_command, 0);
    s3 = 0; tick();

    // restart mid-sequence; OCW3 before ready ignored
    wr1(8'h10); wra(8'h20);
    wr1(8'h13);
    chk("t5_restart", init_done, 0);
    chk("t5_imr", interrupt_mask, IMR_P);
    wr3(8'h0B);
    chk("t5_ocw3_ign", read_isr_select, 0);
    wra(8'h40); wra(8'h01);
    chk("t5_done", init_done, 1);

    // reset in READY
    wra(8'hF0);
    reset = 1; tick(); reset = 0; tick();
    chk("t6_done", init_done, 0);
    wra(8'h77);
    chk("t6_imr", interrupt_mask, IMR_P);

    // random strobes, data and readback
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus = 8'($urandom());
      if ($urandom_range(0, 19) == 0) s1 = ~s1;
      if ($urandom_range(0, 2) == 0) sa = ~sa;
      if ($urandom_range(0, 3) == 0) s3 = ~s3;
      rd = 1'($urandom()); a0 = 1'($urandom());
      irr = 8'($urandom()); isr = 8'($urandom());
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
